// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM state
// encoding, the most-negative operand constant and the counter width helper.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    localparam logic [MD_WIDTH-1:0] MIN_INT = {1'b1, {(MD_WIDTH-1){1'b0}}};

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int MD_CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/is_zero.sv
// Zero detector: zero is 1 when every bit of data is 0.
module is_zero #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    output logic             zero
);

    assign zero = ~|data;

endmodule

// File: rtl/multdiv_datapath.sv
// Shared shift-register datapath for radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with final sign fix-up.
// hi/lo form the product (multiply) or remainder/quotient (divide);
// addend holds |A| for multiply and |B| for divide.
module multdiv_datapath
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    logic [WIDTH:0]     hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   addend;
    logic               neg;
    logic               is_div;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] sprod;
    logic [WIDTH-1:0]   quo;

    // Magnitudes and per-iteration add / trial-subtract terms.
    always_comb begin
        mag_a   = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
        mag_b   = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
        sum     = {1'b0, hi[WIDTH-1:0]} + {1'b0, addend};
        shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, addend});
        diff    = shifted - {1'b0, addend};
    end

    // Load magnitudes on start, then one multiply or divide iteration per step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi     <= '0;
            lo     <= '0;
            addend <= '0;
            neg    <= 1'b0;
            is_div <= 1'b0;
        end else if (load) begin
            hi     <= '0;
            lo     <= div_sel ? mag_a : mag_b;
            addend <= div_sel ? mag_b : mag_a;
            neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            is_div <= div_sel;
        end else if (step) begin
            if (is_div) begin
                hi <= ge ? diff : shifted;
                lo <= {lo[WIDTH-2:0], ge};
            end else if (lo[0]) begin
                hi <= {1'b0, sum[WIDTH:1]};
                lo <= {sum[0], lo[WIDTH-1:1]};
            end else begin
                hi <= {1'b0, hi[WIDTH:1]};
                lo <= {hi[0], lo[WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up and overflow detection on the finished magnitudes.
    // A positive quotient with the top bit set only arises from MIN_INT / -1.
    always_comb begin
        prod      = {hi[WIDTH-1:0], lo};
        sprod     = neg ? (~prod + 1'b1) : prod;
        quo       = neg ? (~lo + 1'b1) : lo;
        result    = is_div ? quo : sprod[WIDTH-1:0];
        exception = is_div ? (~neg & lo[WIDTH-1])
                           : ~((&sprod[2*WIDTH-1:WIDTH-1]) | ~(|sprod[2*WIDTH-1:WIDTH-1]));
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit for the execute stage.
// Optional build macro MULTDIV_EARLY_ZERO_EN: a zero multiply operand or a
// zero dividend finishes in two edges with result 0 / exception 0.
// Divide-by-zero always finishes in two edges with result 0 / exception 1.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// MULT  | WIDTH shift-add iterations, then one edge to publish
// DIV   | WIDTH restoring iterations, then one edge to publish
// DONE  | result valid, data_resultRDY high for this cycle
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    md_state_e        state;
    logic [CW-1:0]    cnt;
    logic             fin;
    logic             skip;
    logic             skip_exc;

    logic             start;
    logic             divisor_zero;
    logic             early_zero;
    logic             skip_now;
    logic             step;
    logic [WIDTH-1:0] dp_result;
    logic             dp_exception;

    is_zero #(.WIDTH(WIDTH)) u_divisor_zero (
        .data (data_operandB),
        .zero (divisor_zero)
    );

`ifdef MULTDIV_EARLY_ZERO_EN
    // Zero product or zero quotient is known up front; no need to iterate.
    always_comb begin
        early_zero = (~|data_operandA) | (ctrl_MULT & ~|data_operandB);
    end
`else
    // Zero operands take the full iteration count.
    always_comb begin
        early_zero = 1'b0;
    end
`endif

    // Start decode; MULT has priority when both controls are high.
    always_comb begin
        start    = ctrl_MULT | ctrl_DIV;
        skip_now = (~ctrl_MULT & divisor_zero) | early_zero;
        step     = ((state == MULT) || (state == DIV)) & ~fin & ~skip & ~start;
    end

    multdiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (start),
        .step      (step),
        .div_sel   (~ctrl_MULT),
        .op_a      (data_operandA),
        .op_b      (data_operandB),
        .result    (dp_result),
        .exception (dp_exception)
    );

    // Sequencing FSM; a start in any state restarts, dropping any pending RDY.
    // fin marks that the iterations (or the early-exit wait) are complete so
    // the next edge publishes the result and enters DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            fin            <= 1'b0;
            skip           <= 1'b0;
            skip_exc       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            state    <= ctrl_MULT ? MULT : DIV;
            cnt      <= '0;
            fin      <= 1'b0;
            skip     <= skip_now;
            skip_exc <= ~ctrl_MULT & divisor_zero;
        end else begin
            case (state)
                MULT, DIV: begin
                    if (fin) begin
                        state          <= DONE;
                        data_result    <= skip ? '0 : dp_result;
                        data_exception <= skip ? skip_exc : dp_exception;
                    end else if (skip) begin
                        fin <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            fin <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        data_resultRDY = (state == DONE);
        busy           = (state != IDLE);
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: hand-computed results, exceptions and
// latencies, plus restart, mid-operation reset and early-zero timing.
module tb_multdiv_unit;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MULTDIV_EARLY_ZERO_EN
    localparam int EZ_LAT = 2;
`else
    localparam int EZ_LAT = 33;
`endif

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Called 1 time unit after a rising edge; the next edge is the start edge.
    // kind: 0 multiply, 1 divide, 2 both controls high.
    task automatic start_op(input int kind, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = (kind != 1);
        ctrl_DIV      = (kind != 0);
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
    endtask

    // Edges counted after the start edge until RDY is seen; -1 on timeout.
    task automatic wait_rdy(input int max_edges, output int lat);
        lat = -1;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input int kind, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input logic exc, input int lat_exp);
        int lat;
        start_op(kind, a, b);
        wait_rdy(40, lat);
        chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, " result"}, data_result, res);
        chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, exc});
        @(posedge clock);
        #1;
        chk({tag, " rdy drop"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, " busy drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        @(posedge clock);
        #1;

        run_op("mul 7*-6",        0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33);
        run_op("mul 2^16*2^16",   0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33);
        run_op("mul -1*MIN",      0, 32'hFFFF_FFFF,  32'h8000_0000, 32'h8000_0000, 1'b1, 33);
        run_op("mul -3*-7",       0, 32'hFFFF_FFFD,  32'hFFFF_FFF9, 32'd21,        1'b0, 33);
        run_op("mul MAX*2",       0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 33);
        run_op("both 6,3",        2, 32'd6,          32'd3,         32'd18,        1'b0, 33);
        run_op("div -100/7",      1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, 33);
        run_op("div MIN/-1",      1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
        run_op("div 7/-2",        1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33);
        run_op("div 5/0",         1, 32'd5,          32'd0,         32'd0,         1'b1, 2);
        run_op("mul 3*4",         0, 32'd3,          32'd4,         32'd12,        1'b0, 33);

        // Restart: divide 100/10, then multiply 3*5 on edge 10 of the divide.
        start_op(1, 32'd100, 32'd10);
        chk("restart busy", {31'd0, busy}, 32'd1);
        chk("restart hold", data_result, 32'd12);
        wait_rdy(9, lat);
        chk("restart no early rdy", 32'(lat), 32'hFFFF_FFFF);
        start_op(0, 32'd3, 32'd5);
        wait_rdy(40, lat);
        chk("restart latency", 32'(lat), 32'd33);
        chk("restart result", data_result, 32'd15);
        wait_rdy(5, lat);
        chk("restart single rdy", 32'(lat), 32'hFFFF_FFFF);

        // Reset low at edge 20 of a multiply aborts it with no RDY.
        start_op(0, 32'd9, 32'd9);
        repeat (19) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort result", data_result, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wait_rdy(40, lat);
        chk("abort no rdy", 32'(lat), 32'hFFFF_FFFF);
        chk("abort exception", {31'd0, data_exception}, 32'd0);

        run_op("mul 0*9",         0, 32'd0,          32'd9,         32'd0,         1'b0, EZ_LAT);
        run_op("div 0/5",         1, 32'd0,          32'd5,         32'd0,         1'b0, EZ_LAT);
        run_op("div 0/0",         1, 32'd0,          32'd0,         32'd0,         1'b1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
